// File: rtl/pdm_sdm2_tx_pkg.sv
// pdm_tx_pkg: shared constants and the saturating clamp for the PCM-to-PDM
// transmitter (pdm_sdm2_tx) and its second-order modulator core (sdm2_core).
package pdm_tx_pkg;

    localparam int PCM_W      = 16;
    localparam int ACC_W_DFLT = 24;
    localparam int FS_POS     = 32768;
    localparam int FS_NEG     = -32768;

    // Clamp a wide signed value into the range of a w-bit two's-complement
    // integrator so the loop never wraps around.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_sdm2_tx_sdm2_core.sv
// sdm2_core: second-order delta-sigma modulator with saturating integrators.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   clr        - synchronous clear of both integrators and the output bit
//   step       - advance the loop by one PDM bit
//   x          - signed input, already sign-extended to ACC_W
//   bit_out    - current 1-bit output (registered, updated on step)
module sdm2_core
    import pdm_tx_pkg::*;
#(
    parameter int ACC_W = ACC_W_DFLT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    step,
    input  logic signed [ACC_W-1:0] x,
    output logic                    bit_out
);

    localparam logic signed [63:0] FB_P = 64'(FS_POS);
    localparam logic signed [63:0] FB_N = 64'(FS_NEG);

    logic signed [ACC_W-1:0] i1_q, i1_d;
    logic signed [ACC_W-1:0] i2_q, i2_d;
    logic                    y_q, y_d;
    logic signed [63:0]      fb, i1n, i2n;

    always_comb begin
        fb   = y_q ? FB_P : FB_N;
        i1n  = sat(64'(i1_q) + 64'(x) - fb, ACC_W);
        i2n  = sat(64'(i2_q) + i1n - fb, ACC_W);
        i1_d = i1_q;
        i2_d = i2_q;
        y_d  = y_q;
        if (clr) begin
            i1_d = '0;
            i2_d = '0;
            y_d  = 1'b0;
        end else if (step) begin
            i1_d = i1n[ACC_W-1:0];
            i2_d = i2n[ACC_W-1:0];
            y_d  = (i2n >= 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q <= '0;
            i2_q <= '0;
            y_q  <= 1'b0;
        end else begin
            i1_q <= i1_d;
            i2_q <= i2_d;
            y_q  <= y_d;
        end
    end

    assign bit_out = y_q;

endmodule

// File: rtl/pdm_sdm2_tx.sv
// pdm_sdm2_tx: PCM-to-PDM transmitter. A one-entry holding buffer takes PCM
// samples over valid/ready; each sample is held for OSR PDM bits and fed to a
// second-order delta-sigma modulator clocked by a divided PDM bit clock.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   en         - modulator enable (low clears divider, counters, integrators)
//   pcm_in     - signed PCM sample; pcm_valid offers it, pcm_ready = buffer empty
//   pdm_clk    - PDM bit clock, 50% duty, rises together with pdm_out updates
//   pdm_out    - PDM data bit
//   underrun   - one-clk pulse when a sample boundary finds the buffer empty
module pdm_sdm2_tx
    import pdm_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int OSR     = 64,
    parameter int ACC_W   = ACC_W_DFLT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_valid,
    output logic                    pcm_ready,
    output logic                    pdm_clk,
    output logic                    pdm_out,
    output logic                    underrun
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(OSR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic signed [PCM_W-1:0] pend_q, pend_d;
    logic signed [PCM_W-1:0] cur_q, cur_d;
    logic                    pend_full_q, pend_full_d;
    logic                    pclk_q, pclk_d;
    logic                    under_q, under_d;
    logic                    tick, bnd, accept;
    logic signed [ACC_W-1:0] x;

    always_comb begin
        tick        = en && (div_q == DIV_LAST);
        bnd         = tick && (bit_q == BIT_LAST);
        accept      = pcm_valid && !pend_full_q;
        div_d       = '0;
        bit_d       = '0;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cur_d       = cur_q;
        under_d     = bnd && !pend_full_q;

        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            bit_d = bit_q;
            if (tick)
                bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
        end
        // Registered from the next divider value so pdm_clk rises on the
        // same edge that updates pdm_out.
        pclk_d = en && (div_d < DIV_HALF);

        if (bnd && pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
        end
        // Accept only happens with the buffer empty, so it never collides
        // with the boundary unload above.
        if (accept) begin
            pend_d      = pcm_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            bit_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cur_q       <= '0;
            pclk_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            div_q       <= div_d;
            bit_q       <= bit_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cur_q       <= cur_d;
            pclk_q      <= pclk_d;
            under_q     <= under_d;
        end
    end

    // Modulator sees the pre-edge cur, so a newly loaded sample affects the
    // tick after its boundary.
    assign x = ACC_W'(cur_q);

    sdm2_core #(
        .ACC_W(ACC_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!en),
        .step   (tick),
        .x      (x),
        .bit_out(pdm_out)
    );

    assign pcm_ready = !pend_full_q;
    assign pdm_clk   = pclk_q;
    assign underrun  = under_q;

endmodule

// File: doc/pdm_sdm2_tx.md
Name: pdm_sdm2_tx

Overview:
- PCM-to-PDM transmitter: the output-side counterpart of the CIC3 PDM decimator. Drives a PDM DAC/amplifier or loopback into the decimator.
- Accepts signed 16-bit PCM samples over a valid/ready handshake into a one-entry holding buffer.
- Applies zero-order-hold upsampling by OSR and converts to a 1-bit stream with a second-order delta-sigma modulator.
- Generates the PDM bit clock from the system clock.

Parameters:
- CLK_DIV, 4, system clocks per PDM bit; even, ≥2.
- OSR, 64, PDM bits per PCM sample; power of two, 2..256.
- ACC_W, 24, integrator width (signed, saturating).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- en  in  1  modulator enable
- pcm_in  in  16  signed PCM sample
- pcm_valid  in  1  sample offered
- pcm_ready  out  1  holding buffer empty
- pdm_clk  out  1  PDM bit clock, 50% duty
- pdm_out  out  1  PDM data, changes when pdm_clk rises
- underrun  out  1  one-clk pulse when a sample boundary finds the buffer empty

Behaviour:
- Reset (async, rst_n low):
  - pdm_out=0, pdm_clk=0, underrun=0.
  - pending buffer empty, so pcm_ready=1.
  - current sample=0, i1=i2=0, y=0, div_cnt=0, bit_cnt=0.
- Handshake:
  - pcm_ready = !pend_full, combinational from state.
  - Accept on valid&&ready: pend <= pcm_in, pend_full <= 1.
  - pcm_valid while ready=0 is ignored; the offered data is not stored.
- Holding buffer is independent of en; it accepts samples while en=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 when en=1.
  - tick = en && div_cnt==CLK_DIV-1.
  - pdm_clk is registered: 1 for div_cnt in [0, CLK_DIV/2-1], else 0.
- Sample boundary = tick && bit_cnt==OSR-1. bit_cnt increments on every tick and wraps to 0 at OSR-1.
- At a boundary:
  - If pend_full (state before this edge): cur <= pend, pend_full <= 0.
  - Else: cur holds its value, underrun=1 for exactly one clk.
  - A same-cycle accept is impossible when pend_full=1. When pend_full=0, the accept fills pend and the boundary still reports underrun.
- Modulator, updated on each tick only:
  - x = sign-extend(cur) to ACC_W.
  - fb = y ? +32768 : -32768.
  - i1n = sat(i1 + x - fb); i2n = sat(i2 + i1n - fb).
  - y <= (i2n >= 0); pdm_out <= y_next, registered on the tick edge.
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap-around is permitted.
- The first tick after a boundary uses the newly loaded cur. cur update and modulator step use the pre-edge cur, so the new sample takes effect one tick later: latency from boundary to first affected bit is 1 PDM bit.
- en=0 (synchronous):
  - div_cnt=0, bit_cnt=0, i1=i2=0, y=0, pdm_out=0, pdm_clk=0.
  - cur retained.
  - First tick occurs CLK_DIV clks after en rises.
- Reset mid-operation returns every register to its reset value immediately, including dropping a pending sample.

Decomposition:
- Package pdm_tx_pkg holds:
  - FS_POS=32768, FS_NEG=-32768
  - PCM_W=16
  - default ACC_W
  - sat() function
- One natural sub-module: sdm2_core.
  - Holds i1, i2, y.
  - Ports: clk, rst_n, clr, step, x, bit_out.
- Divider, counters and handshake stay in the top module.

Test Plan:
1. Reset, en=1, no samples (cur=0):
   - pdm_out sequence over first 4 ticks = 1,1,0,1.
   - ones count over 64 ticks = 32±2.
   - underrun pulses once per 64 ticks.
2. Feed +16384 continuously with valid held high:
   - pcm_ready drops after accept and re-rises one clk after each boundary.
   - Ones density over 256 ticks = 0.75±0.02.
3. Feed +32767 then -32768:
   - Ones ≥62/64 in the first full sample window, ≤2/64 in the next.
   - No integrator wrap: density never flips sign.
4. Backpressure: pcm_valid high with data changing every clk:
   - Exactly one sample accepted per OSR*CLK_DIV clks.
   - The loaded value equals pcm_in in the accept cycle.
5. Toggle en low for 10 clks mid-stream:
   - pdm_clk and pdm_out held 0, pcm_ready behaviour unchanged.
   - After en rises, first pdm_clk rise follows 1 clk later and the first tick follows after CLK_DIV clks.
6. Assert rst_n low asynchronously between clk edges with pend_full=1:
   - Outputs reach reset values before the next edge.
   - pcm_ready=1; no underrun pulse.
